hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and flow-control unit for the 5-stage ARM pipeline. It takes the control and destination fields leaving the ID/EX pipeline register, the source fields of the instruction in ID, and the branch and data-memory status. From these it produces the write-enable, bubble and flush controls that go back into the PC, the IF/ID register and the ID/EX register. A small FSM covers multi-cycle branch flushes and data-memory freezes, and saturating counters record stall and flush events for performance debug.

## Interface
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed and ID/EX is bubbled after a taken branch (1..7)
- CNT_W, 16, width of the stall and flush event counters

- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- memRead_EX  in  1  instruction in EX is a load
- RegWrite_EX  in  1  instruction in EX writes the register file
- set_flags_EX  in  1  instruction in EX updates NZCV
- targetReg_EX  in  5  destination register of the instruction in EX
- instr_valid_ID  in  1  ID holds a real instruction, not a bubble
- Rn_ID, Rm_ID  in  5 each  source register numbers in ID
- uses_Rn_ID, uses_Rm_ID  in  1 each  the ID instruction actually reads Rn / Rm
- flag_use_ID  in  1  the ID instruction is a conditional branch that reads NZCV
- branch_taken_EX  in  1  branch resolved taken in EX this cycle
- mem_busy_MEM  in  1  data memory cannot complete the access in MEM this cycle
- pc_write_en  out  1  PC may update
- if_id_write_en  out  1  IF/ID may load
- if_id_flush  out  1  IF/ID loads a NOP (instr_valid = 0)
- id_ex_bubble  out  1  ID/EX loads all control bits = 0
- pipe_freeze  out  1  EX/MEM and MEM/WB hold their contents
- stall_cnt  out  CNT_W  saturating count of load-use and flag stall cycles
- flush_cnt  out  CNT_W  saturating count of taken-branch events

## Operation
- State register takes one of RUN, FLUSH, FREEZE. It also holds flush_left (3 bits), stall_cnt and flush_cnt.
- Hazard terms are combinational from the current inputs:
  - load_use = memRead_EX & targetReg_EX != 31 & instr_valid_ID & ((uses_Rn_ID & Rn_ID == targetReg_EX) | (uses_Rm_ID & Rm_ID == targetReg_EX)). X31 (XZR) never creates a hazard.
  - flag_haz = set_flags_EX & flag_use_ID & instr_valid_ID.
- Priority, highest first: reset, then mem_busy_MEM / FREEZE, then branch_taken_EX / FLUSH, then load_use or flag_haz, then normal flow.
- Freeze (mem_busy_MEM = 1, in any state):
  - pipe_freeze=1, pc_write_en=0, if_id_write_en=0.
  - id_ex_bubble=0 and if_id_flush=0, because ID/EX holds its contents.
  - Next state is FREEZE. flush_left holds and the counters hold.
- FREEZE with mem_busy_MEM = 0 returns to FLUSH if flush_left != 0, otherwise to RUN. The hazard terms are evaluated normally in that same cycle.
- Taken branch (in RUN, not frozen):
  - if_id_flush=1, id_ex_bubble=1, pc_write_en=1 (PC loads the branch target), if_id_write_en=1.
  - flush_cnt increments.
  - flush_left loads FLUSH_CYCLES-1. Next state is FLUSH if that value is nonzero, otherwise RUN.
- FLUSH (not frozen):
  - Outputs are the same as for a taken branch, except flush_cnt does not increment.
  - flush_left decrements, and the state goes to RUN when flush_left reaches 0.
  - A branch_taken_EX arriving in FLUSH is ignored; it is a wrong-path instruction.
- Stall (RUN, no branch, load_use | flag_haz):
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, if_id_flush=0.
  - stall_cnt increments.
  - The bubble makes the hazard clear next cycle. No state change.
- Normal flow: pc_write_en=1, if_id_write_en=1, all other outputs 0.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- All outputs are combinational from the inputs and the registered state. There is no added latency; controls act at the same clock edge the hazard is seen.
- Load-use costs exactly 1 bubble cycle. A flag hazard costs 1 cycle. A taken branch costs FLUSH_CYCLES cycles plus any freeze cycles in between.
- While reset=1:
  - pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_bubble=1, pipe_freeze=0.
  - On the edge, state becomes RUN and flush_left, stall_cnt and flush_cnt become 0.
- A reset asserted mid-FLUSH or mid-FREEZE aborts it; the first cycle after reset is in RUN.
- When load_use and branch_taken_EX are both true, only the branch action occurs and stall_cnt does not increment.

## Test plan
- Load-use: LDUR X2 in EX, ADD X3,X2,X4 in ID (uses_Rn, Rn=2) -> 1 cycle with pc_write_en=0, id_ex_bubble=1; stall_cnt=1; next cycle normal.
- XZR and no-read: load to X31 with Rn_ID=31 -> no stall. Load to X5 with Rm_ID=5 but uses_Rm_ID=0 -> no stall.
- Branch with FLUSH_CYCLES=2: branch_taken_EX pulse -> if_id_flush=1 and id_ex_bubble=1 for 2 cycles, flush_cnt=1. A second branch_taken_EX in cycle 2 is ignored.
- Freeze mid-flush: FLUSH_CYCLES=3, mem_busy_MEM high for 4 cycles starting the cycle after the branch -> pipe_freeze=1 for 4 cycles, then the remaining 2 flush cycles complete.
- Reset during FLUSH -> outputs take reset values; the next cycle is RUN with counters at 0.
- Saturation with CNT_W=4: 20 load-use stalls -> stall_cnt stays at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and flow-control unit for the 5-stage pipeline: load-use and flag stalls,
// multi-cycle taken-branch flushes, data-memory freezes and saturating event counters.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead_EX,
  input  logic             RegWrite_EX,
  input  logic             set_flags_EX,
  input  logic [4:0]       targetReg_EX,
  input  logic             instr_valid_ID,
  input  logic [4:0]       Rn_ID,
  input  logic [4:0]       Rm_ID,
  input  logic             uses_Rn_ID,
  input  logic             uses_Rm_ID,
  input  logic             flag_use_ID,
  input  logic             branch_taken_EX,
  input  logic             mem_busy_MEM,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [2:0]       flush_left, flush_left_nxt;
  logic [CNT_W-1:0] stall_cnt_nxt, flush_cnt_nxt;
  logic             load_use, flag_haz, in_flush;

  // A load always writes its target, so memRead_EX alone qualifies the hazard.
  logic unused_inputs;
  assign unused_inputs = RegWrite_EX;

  assign load_use = memRead_EX && (targetReg_EX != 5'd31) && instr_valid_ID &&
                    ((uses_Rn_ID && (Rn_ID == targetReg_EX)) ||
                     (uses_Rm_ID && (Rm_ID == targetReg_EX)));
  assign flag_haz = set_flags_EX && flag_use_ID && instr_valid_ID;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    state_nxt      = state;
    flush_left_nxt = flush_left;
    stall_cnt_nxt  = stall_cnt;
    flush_cnt_nxt  = flush_cnt;
    in_flush       = 1'b0;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    pipe_freeze    = 1'b0;

    if (reset) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
    end else if (mem_busy_MEM) begin
      // ID/EX holds, so no bubble or flush is injected while frozen.
      pipe_freeze    = 1'b1;
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      state_nxt      = FREEZE;
    end else begin
      state_nxt = RUN;
      // Leaving FREEZE resumes an interrupted flush if one is still pending.
      in_flush  = (state == FLUSH) || ((state == FREEZE) && (flush_left != 3'd0));
      if (in_flush) begin
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
        flush_left_nxt = flush_left - 3'd1;
        state_nxt      = (flush_left == 3'd1) ? RUN : FLUSH;
      end else if (branch_taken_EX) begin
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
        flush_left_nxt = FLUSH_INIT;
        state_nxt      = (FLUSH_INIT != 3'd0) ? FLUSH : RUN;
        if (flush_cnt != CNT_MAX) flush_cnt_nxt = flush_cnt + CNT_ONE;
      end else if (load_use || flag_haz) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
        if (stall_cnt != CNT_MAX) stall_cnt_nxt = stall_cnt + CNT_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flush_left <= 3'd0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
      stall_cnt  <= stall_cnt_nxt;
      flush_cnt  <= flush_cnt_nxt;
    end
  end

endmodule
